// File: rtl/motor_puertas_if.sv
// Door mechanism link: controller commands and obstruction sensor in,
// door status, open-hold timeout and travel position out.
interface motor_puertas_if #(
    parameter int unsigned POS_W = 4
);
    logic [1:0]       comando;
    logic             sensor;
    logic [1:0]       puertas;
    logic             timeout;
    logic [POS_W-1:0] posicion;

    modport master (
        output comando,
        output sensor,
        input  puertas,
        input  timeout,
        input  posicion
    );

    modport slave (
        input  comando,
        input  sensor,
        output puertas,
        output timeout,
        output posicion
    );
endinterface

// File: rtl/motor_puertas.sv
// Cycle-accurate door mechanism: travel counter with safety reversal on
// obstruction and an open-hold timer that raises timeout when left idle.
module motor_puertas #(
    parameter int unsigned T_MOVE    = 8,
    parameter int unsigned POS_W     = 4,
    parameter int unsigned T_ABIERTA = 20,
    parameter int unsigned TMR_W     = 6
) (
    input logic               clk,
    input logic               reset,
    motor_puertas_if.slave    bus
);

    // Encoding doubles as the puertas output code.
    typedef enum logic [1:0] {
        StCerrada  = 2'b00,
        StAbierta  = 2'b01,
        StCerrando = 2'b10,
        StAbriendo = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
    logic             abrir, cerrar;

    always_comb begin
        abrir     = (bus.comando == 2'b01);
        cerrar    = (bus.comando == 2'b10);
        state_d   = state_q;
        pos_d     = pos_q;
        tmr_d     = '0;
        unique case (state_q)
            StCerrada: begin
                pos_d = '0;
                if (abrir) state_d = StAbriendo;
            end
            StAbriendo: begin
                if (cerrar && !bus.sensor) begin
                    state_d = StCerrando;
                end else if (pos_q >= POS_W'(T_MOVE - 1)) begin
                    // Also covers a reversal that began at full travel.
                    state_d = StAbierta;
                    pos_d   = POS_W'(T_MOVE);
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
            StAbierta: begin
                pos_d = POS_W'(T_MOVE);
                if (cerrar && !bus.sensor) begin
                    state_d = StCerrando;
                end else if (bus.sensor || abrir) begin
                    tmr_d = '0;
                end else if (tmr_q < TMR_W'(T_ABIERTA)) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end else begin
                    tmr_d = tmr_q;
                end
            end
            StCerrando: begin
                if (bus.sensor || abrir) begin
                    state_d = StAbriendo;
                end else if (pos_q <= POS_W'(1)) begin
                    state_d = StCerrada;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q - POS_W'(1);
                end
            end
            default: begin
                state_d = StCerrada;
                pos_d   = '0;
            end
        endcase
        timeout_d = (state_d == StAbierta) && (tmr_d == TMR_W'(T_ABIERTA));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StCerrada;
            pos_q     <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.puertas  = state_q;
    assign bus.timeout  = timeout_q;
    assign bus.posicion = pos_q;

endmodule

// File: tb/tb_motor_puertas.sv
// Self-checking bench for motor_puertas: vector table, directed corner cases,
// and randomized traffic against a position/direction reference model.
module tb_motor_puertas;

    localparam int unsigned TM = 8;
    localparam int unsigned PW = 4;
    localparam int unsigned TA = 20;
    localparam int unsigned TW = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    motor_puertas_if #(.POS_W(PW)) bus ();

    motor_puertas #(
        .T_MOVE   (TM),
        .POS_W    (PW),
        .T_ABIERTA(TA),
        .TMR_W    (TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position, travel direction (+1/-1/0) and idle-open counter.
    int m_pos  = 0;
    int m_dir  = 0;
    int m_hold = 0;

    task automatic model(input logic r, input logic [1:0] c, input logic s);
        bit ab, ce;
        ab = (c == 2'd1);
        ce = (c == 2'd2);
        if (r) begin
            m_pos = 0; m_dir = 0; m_hold = 0;
        end else if (m_dir > 0) begin
            if (ce && !s) m_dir = -1;
            else begin
                m_pos = (m_pos + 1 > int'(TM)) ? int'(TM) : m_pos + 1;
                if (m_pos == int'(TM)) begin m_dir = 0; m_hold = 0; end
            end
        end else if (m_dir < 0) begin
            if (s || ab) m_dir = 1;
            else begin
                m_pos = (m_pos > 0) ? m_pos - 1 : 0;
                if (m_pos == 0) m_dir = 0;
            end
        end else if (m_pos == int'(TM)) begin
            if (ce && !s) begin m_dir = -1; m_hold = 0; end
            else if (s || ab) m_hold = 0;
            else if (m_hold < int'(TA)) m_hold++;
        end else begin
            if (ab) m_dir = 1;
        end
    endtask

    function automatic int m_puertas();
        if (m_dir > 0) return 3;
        if (m_dir < 0) return 2;
        return (m_pos == int'(TM)) ? 1 : 0;
    endfunction

    function automatic int m_timeout();
        return (m_dir == 0 && m_pos == int'(TM) && m_hold == int'(TA)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic s);
        reset       = r;
        bus.comando = c;
        bus.sensor  = s;
        @(posedge clk);
        model(r, c, s);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] cmd;
        logic       sen;
        logic [1:0] p;
        logic [3:0] pos;
        logic       to;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n;
        vecs = '{
            '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0},
            '{1'b0, 2'b10, 1'b0, 2'b00, 4'd0, 1'b0},
            '{1'b0, 2'b11, 1'b1, 2'b00, 4'd0, 1'b0},
            '{1'b0, 2'b01, 1'b0, 2'b11, 4'd0, 1'b0},
            '{1'b0, 2'b00, 1'b1, 2'b11, 4'd1, 1'b0},
            '{1'b0, 2'b11, 1'b0, 2'b11, 4'd2, 1'b0},
            '{1'b0, 2'b00, 1'b0, 2'b11, 4'd3, 1'b0},
            '{1'b0, 2'b01, 1'b0, 2'b11, 4'd4, 1'b0},
            '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0},
            '{1'b0, 2'b01, 1'b0, 2'b11, 4'd0, 1'b0},
            '{1'b0, 2'b10, 1'b1, 2'b11, 4'd1, 1'b0},
            '{1'b0, 2'b10, 1'b0, 2'b10, 4'd1, 1'b0},
            '{1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0},
            '{1'b0, 2'b01, 1'b0, 2'b11, 4'd0, 1'b0},
            '{1'b0, 2'b10, 1'b0, 2'b10, 4'd0, 1'b0},
            '{1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0}
        };
        reset = 1'b1;
        bus.comando = 2'b00;
        bus.sensor  = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].cmd, vecs[i].sen);
            chk($sformatf("vec%0d_puertas", i), 32'(bus.puertas), 32'(vecs[i].p));
            chk($sformatf("vec%0d_pos", i), 32'(bus.posicion), 32'(vecs[i].pos));
            chk($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'(vecs[i].to));
        end

        // Full opening travel.
        step(1'b0, 2'b01, 1'b0);
        chk("open_puertas0", 32'(bus.puertas), 32'd3);
        chk("open_pos0", 32'(bus.posicion), 32'd0);
        for (int i = 1; i < int'(TM); i++) begin
            step(1'b0, 2'b00, 1'b0);
            chk("open_puertas", 32'(bus.puertas), 32'd3);
            chk("open_pos", 32'(bus.posicion), 32'(i));
        end
        step(1'b0, 2'b00, 1'b0);
        chk("opened_puertas", 32'(bus.puertas), 32'd1);
        chk("opened_pos", 32'(bus.posicion), 32'(TM));
        chk("opened_timeout", 32'(bus.timeout), 32'd0);

        // Idle open hold: timeout after exactly TA cycles, then held.
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b00, 1'b0);
            n++;
            if (bus.timeout === 1'b1) break;
        end
        chk("timeout_latency", 32'(n), 32'(TA));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b00, 1'b0);
            chk("timeout_hold", 32'(bus.timeout), 32'd1);
        end
        step(1'b0, 2'b11, 1'b0);
        chk("cmd11_open_puertas", 32'(bus.puertas), 32'd1);
        chk("cmd11_open_timeout", 32'(bus.timeout), 32'd1);
        step(1'b0, 2'b10, 1'b1);
        chk("close_obstructed_puertas", 32'(bus.puertas), 32'd1);
        chk("close_obstructed_timeout", 32'(bus.timeout), 32'd0);

        // Sensor pulse restarts the hold timer.
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        chk("pulse_timeout", 32'(bus.timeout), 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b00, 1'b0);
            n++;
            if (bus.timeout === 1'b1) break;
        end
        chk("pulse_latency", 32'(n), 32'(TA));

        // Safety reversal at pos 5 while closing.
        step(1'b0, 2'b10, 1'b0);
        chk("close_puertas", 32'(bus.puertas), 32'd2);
        chk("close_pos", 32'(bus.posicion), 32'(TM));
        chk("close_timeout", 32'(bus.timeout), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 1'b0);
        chk("closing_pos5", 32'(bus.posicion), 32'd5);
        step(1'b0, 2'b10, 1'b1);
        chk("reverse_puertas", 32'(bus.puertas), 32'd3);
        chk("reverse_pos", 32'(bus.posicion), 32'd5);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        chk("reopen_mid", 32'(bus.puertas), 32'd3);
        step(1'b0, 2'b00, 1'b0);
        chk("reopen_puertas", 32'(bus.puertas), 32'd1);
        chk("reopen_pos", 32'(bus.posicion), 32'(TM));

        // Randomized traffic, alternating busy and quiet blocks.
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < 100; i++) begin
                logic       r;
                logic [1:0] c;
                logic       s;
                int         sel;
                r   = ($urandom_range(0, 199) == 0);
                sel = (blk % 2 == 1) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 19));
                case (sel)
                    0, 1:    c = 2'b01;
                    2, 3:    c = 2'b10;
                    4:       c = 2'b11;
                    default: c = 2'b00;
                endcase
                s = ($urandom_range(0, 11) == 0);
                step(r, c, s);
                chk("rand_puertas", 32'(bus.puertas), 32'(m_puertas()));
                chk("rand_pos", 32'(bus.posicion), 32'(m_pos));
                chk("rand_timeout", 32'(bus.timeout), 32'(m_timeout()));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
